// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_ctrl                                                            |
// | Stall/flush controller: load-use bubbles, taken-branch flushes and a     |
// | MEM-stage request/ack sequencer that freezes the pipeline per access.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             Branch_taken_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             PipeStall_o,
  output logic             mem_req_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic w_acc;
  logic w_lu;
  logic w_ack;
  logic w_tmo;
  logic w_stall;
  logic w_req;
  logic w_bubble;
  logic w_flush;
  logic w_advance;

  assign w_acc = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign w_lu  = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                 ((IDEX_RDaddr_i == IFID_RS1addr_i) || (IDEX_RDaddr_i == IFID_RS2addr_i));

  // Memory access sequencer; an ack in the last WAIT cycle wins over timeout.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_ack   = 1'b0;
    w_tmo   = 1'b0;
    case (state_q)
      S_RUN: begin
        w_req   = w_acc;
        w_stall = w_acc;
        if (w_acc) begin
          state_d = S_WAIT;
          timer_d = 8'd0;
        end
      end
      S_WAIT: begin
        w_req   = 1'b1;
        w_ack   = mem_ack_i;
        w_tmo   = !mem_ack_i && (timer_q == TMO_LAST);
        w_stall = !(w_ack || w_tmo);
        if (w_ack || w_tmo) begin
          state_d = S_RUN;
        end else begin
          timer_d = timer_q + 8'd1;
        end
        if (w_tmo) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // A frozen ID stage defers both hazards; they are seen again on release.
  always_comb begin
    w_bubble  = 1'b0;
    w_flush   = 1'b0;
    w_advance = 1'b0;
    if (!w_stall) begin
      if (w_lu) begin
        w_bubble = 1'b1;
      end else begin
        w_advance = 1'b1;
        w_flush   = Branch_taken_i;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((w_stall || w_bubble) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (w_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q     <= S_RUN;
      timer_q     <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCWrite_o    = w_advance;
  assign IFIDWrite_o  = w_advance;
  assign IFIDFlush_o  = w_flush;
  assign IDEXBubble_o = w_bubble;
  assign PipeStall_o  = w_stall;
  assign mem_req_o    = w_req;
  assign err_o        = err_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_ctrl                                                         |
// | Directed and randomized bench against a cycle-level reference model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             start_i;
  logic [4:0]       IFID_RS1addr_i;
  logic [4:0]       IFID_RS2addr_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RDaddr_i;
  logic             Branch_taken_i;
  logic             EXMEM_MemRead_i;
  logic             EXMEM_MemWrite_i;
  logic             mem_ack_i;
  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             IFIDFlush_o;
  logic             IDEXBubble_o;
  logic             PipeStall_o;
  logic             mem_req_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  pipeline_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk_i            (clk_i),
    .start_i          (start_i),
    .IFID_RS1addr_i   (IFID_RS1addr_i),
    .IFID_RS2addr_i   (IFID_RS2addr_i),
    .IDEX_MemRead_i   (IDEX_MemRead_i),
    .IDEX_RDaddr_i    (IDEX_RDaddr_i),
    .Branch_taken_i   (Branch_taken_i),
    .EXMEM_MemRead_i  (EXMEM_MemRead_i),
    .EXMEM_MemWrite_i (EXMEM_MemWrite_i),
    .mem_ack_i        (mem_ack_i),
    .PCWrite_o        (PCWrite_o),
    .IFIDWrite_o      (IFIDWrite_o),
    .IFIDFlush_o      (IFIDFlush_o),
    .IDEXBubble_o     (IDEXBubble_o),
    .PipeStall_o      (PipeStall_o),
    .mem_req_o        (mem_req_o),
    .err_o            (err_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "in an access" flag plus number of WAIT cycles spent.
  bit m_busy;
  int m_spent;
  bit m_err;
  int m_stall_cnt;
  int m_flush_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy      = 1'b0;
    m_spent     = 0;
    m_err       = 1'b0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic drive(input int rs1, input int rs2, input int rd, input bit ld,
                       input bit br, input bit mrd, input bit mwr, input bit ack);
    IFID_RS1addr_i   = 5'(rs1);
    IFID_RS2addr_i   = 5'(rs2);
    IDEX_RDaddr_i    = 5'(rd);
    IDEX_MemRead_i   = ld;
    Branch_taken_i   = br;
    EXMEM_MemRead_i  = mrd;
    EXMEM_MemWrite_i = mwr;
    mem_ack_i        = ack;
  endtask

  // Compare one cycle at the falling edge, advance the model, return after the next rising edge.
  task automatic step();
    bit acc, lu, ack, tmo, stall, req, bubble, flush, adv;
    @(negedge clk_i);
    if (!start_i) model_reset();
    acc = EXMEM_MemRead_i || EXMEM_MemWrite_i;
    lu  = IDEX_MemRead_i && (IDEX_RDaddr_i != 0) &&
          (IDEX_RDaddr_i == IFID_RS1addr_i || IDEX_RDaddr_i == IFID_RS2addr_i);
    if (m_busy) begin
      req   = 1'b1;
      ack   = mem_ack_i;
      tmo   = !ack && (m_spent == TIMEOUT - 1);
      stall = !(ack || tmo);
    end else begin
      req   = acc;
      ack   = 1'b0;
      tmo   = 1'b0;
      stall = acc;
    end
    bubble = !stall && lu;
    adv    = !stall && !lu;
    flush  = adv && Branch_taken_i;
    check("ctrl", 32'({PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeStall_o, mem_req_o, err_o}),
          32'({adv, adv, flush, bubble, stall, req, m_err}));
    check("stall_cnt", 32'(stall_cnt_o), 32'(m_stall_cnt));
    check("flush_cnt", 32'(flush_cnt_o), 32'(m_flush_cnt));
    if (start_i) begin
      if (stall || bubble) m_stall_cnt = (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : CNT_MAX;
      if (flush)           m_flush_cnt = (m_flush_cnt < CNT_MAX) ? m_flush_cnt + 1 : CNT_MAX;
      if (!m_busy) begin
        if (acc) begin
          m_busy  = 1'b1;
          m_spent = 0;
        end
      end else if (ack || tmo) begin
        m_busy = 1'b0;
        if (tmo) m_err = 1'b1;
      end else begin
        m_spent++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    start_i = 1'b0;
    step();
    start_i = 1'b1;
  endtask

  initial begin
    start_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    step();
    step();
    check("rst_err", 32'(err_o), 32'd0);
    start_i = 1'b1;

    // Load-use hazard, then the same with x0 as destination.
    drive(1, 5, 5, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("lu_cnt", 32'(stall_cnt_o), 32'd1);
    drive(0, 0, 0, 1, 0, 0, 0, 0); step();
    check("lu_x0_cnt", 32'(stall_cnt_o), 32'd1);

    // Taken branch, then branch together with a load-use hazard.
    drive(0, 0, 0, 0, 1, 0, 0, 0); step();
    check("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
    drive(3, 0, 3, 1, 1, 0, 0, 0); step();
    check("br_lu_flush_cnt", 32'(flush_cnt_o), 32'd1);
    check("br_lu_stall_cnt", 32'(stall_cnt_o), 32'd2);

    // Load in MEM, ack three cycles after the request starts.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0); step(); step(); step();
    drive(0, 0, 0, 0, 0, 1, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("ack3_stall_cnt", 32'(stall_cnt_o), 32'd3);

    // Timeout with a taken branch held across the stall.
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < TIMEOUT + 1; i++) step();
    check("tmo_err", 32'(err_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("tmo_err_sticky", 32'(err_o), 32'd1);
    check("tmo_flush_cnt", 32'(flush_cnt_o), 32'd1);

    // Ack in the last WAIT cycle is an ack, not a timeout.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) step();
    drive(0, 0, 0, 0, 0, 1, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("late_ack_err", 32'(err_o), 32'd0);

    // Reset in the second WAIT cycle, access re-requested afterwards.
    drive(0, 0, 0, 0, 0, 1, 0, 0); step(); step();
    start_i = 1'b0; step();
    start_i = 1'b1; step();
    check("rst_wait_req", 32'(mem_req_o), 32'd1);

    // Saturation: keep the access pending well beyond the counter range.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2 * CNT_MAX; i++) step();
    check("sat_stall_cnt", 32'(stall_cnt_o), 32'(CNT_MAX));

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      start_i = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
